ppc_regs: RTL and testbench

PPC_REGS -- requirements
Module: ppc_regs

---
 rtl/ppc_regs.sv | 71 +++++++
 tb/tb_ppc_regs.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ppc_regs.sv
// ppc_regs: 32 x 64-bit register file with two registered read ports and two write ports.
// All buses use big-endian bit numbering (bit 0 is the MSB).
// When two writes hit the same register in one cycle, write port 1 wins.
// Optional macro REGS_BYPASS_EN: a read that hits a same-cycle write returns the new data.
// If both write ports hit the read address, the port 1 data is returned.
// With the macro undefined, such a read returns the pre-write contents.
module ppc_regs #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren0,
  input  logic [0:ADDR_W-1] raddr0,
  output logic [0:DATA_W-1] rdata0,
  input  logic              ren1,
  input  logic [0:ADDR_W-1] raddr1,
  output logic [0:DATA_W-1] rdata1,
  input  logic              wen0,
  input  logic [0:ADDR_W-1] waddr0,
  input  logic [0:DATA_W-1] wdata0,
  input  logic              wen1,
  input  logic [0:ADDR_W-1] waddr1,
  input  logic [0:DATA_W-1] wdata1
);

  localparam int NREG = 2 ** ADDR_W;

  logic [0:DATA_W-1] regs [0:NREG-1];
  logic [0:DATA_W-1] rd_next0;
  logic [0:DATA_W-1] rd_next1;

  // Value a read port captures at the next edge. Bypass optionally forwards same-cycle write data.
  function automatic logic [0:DATA_W-1] rd_sel(input logic [0:ADDR_W-1] a);
    logic [0:DATA_W-1] d;
    d = regs[a];
`ifdef REGS_BYPASS_EN
    if (wen0 && (waddr0 == a)) d = wdata0;
    if (wen1 && (waddr1 == a)) d = wdata1;
`endif
    return d;
  endfunction

  // Register array update. Port 1 is applied last so it wins on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wen0) regs[waddr0] <= wdata0;
      if (wen1) regs[waddr1] <= wdata1;
    end
  end

  // Read-data selection for both ports.
  always_comb begin
    rd_next0 = rd_sel(raddr0);
    rd_next1 = rd_sel(raddr1);
  end

  // Registered read outputs. Each output holds its value while its enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (ren0) rdata0 <= rd_next0;
      if (ren1) rdata1 <= rd_next1;
    end
  end

endmodule

// File: tb/tb_ppc_regs.sv
// Self-checking bench for ppc_regs: a vector table plus hand-written reset sequences.
module tb_ppc_regs;

  logic        clk;
  logic        rst;
  logic        ren0, ren1, wen0, wen1;
  logic [0:4]  raddr0, raddr1, waddr0, waddr1;
  logic [0:63] wdata0, wdata1;
  logic [0:63] rdata0, rdata1;

  int errors = 0;
  int checks = 0;

  ppc_regs dut (
    .clk(clk), .rst(rst),
    .ren0(ren0), .raddr0(raddr0), .rdata0(rdata0),
    .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ren0;
    logic [4:0]  raddr0;
    logic        ren1;
    logic [4:0]  raddr1;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [63:0] wdata0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [63:0] wdata1;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] V41   = 64'h0000_0000_0000_0041;
  localparam logic [63:0] V1111 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] V2222 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] V3333 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] V4444 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] VAAAA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] V5555 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] VDEAD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] V10   = 64'h0000_0000_0000_0010;
  localparam logic [63:0] V20   = 64'h0000_0000_0000_0020;

`ifdef REGS_BYPASS_EN
  localparam logic [63:0] COLL7 = V5555;
  localparam logic [63:0] COLL0 = VDEAD;
`else
  localparam logic [63:0] COLL7 = VAAAA;
  localparam logic [63:0] COLL0 = 64'h0;
`endif

  task automatic add(input string nm,
                     input logic r0, input logic [4:0] ra0,
                     input logic r1, input logic [4:0] ra1,
                     input logic w0, input logic [4:0] wa0, input logic [63:0] wd0,
                     input logic w1, input logic [4:0] wa1, input logic [63:0] wd1,
                     input logic [63:0] e0, input logic [63:0] e1);
    vec_t v;
    v.name = nm; v.ren0 = r0; v.raddr0 = ra0; v.ren1 = r1; v.raddr1 = ra1;
    v.wen0 = w0; v.waddr0 = wa0; v.wdata0 = wd0;
    v.wen1 = w1; v.waddr1 = wa1; v.wdata1 = wd1;
    v.exp0 = e0; v.exp1 = e1;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ren0 = 0; ren1 = 0; wen0 = 0; wen1 = 0;
    raddr0 = '0; raddr1 = '0; waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    check("reset_rdata0", rdata0, 64'h0);
    check("reset_rdata1", rdata1, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    //   name            ren0 ra0 ren1 ra1 wen0 wa0 wd0  wen1 wa1 wd1  exp0 exp1
    add("wr_r3",         0, 0,  0, 0,  1, 3, V41,   0, 0, 0,     0,     0);
    add("rd_r3_both",    1, 3,  1, 3,  0, 0, 0,     0, 0, 0,     V41,   V41);
    add("wr_same_r5",    0, 0,  0, 0,  1, 5, V1111, 1, 5, V2222, V41,   V41);
    add("rd_r5_p1wins",  1, 5,  0, 0,  0, 0, 0,     0, 0, 0,     V2222, V41);
    add("wr_r5_r6",      0, 0,  0, 0,  1, 5, V3333, 1, 6, V4444, V2222, V41);
    add("rd_r5_r6",      1, 5,  1, 6,  0, 0, 0,     0, 0, 0,     V3333, V4444);
    add("wr_r7_aaaa",    0, 0,  0, 0,  1, 7, VAAAA, 0, 0, 0,     V3333, V4444);
    add("rdwr_r7",       1, 7,  1, 0,  0, 0, 0,     1, 7, V5555, COLL7, 64'h0);
    add("rd_r7_new",     1, 7,  1, 31, 0, 0, 0,     0, 0, 0,     V5555, 64'h0);
    add("rdwr_r0",       0, 0,  1, 0,  1, 0, VDEAD, 0, 0, 0,     V5555, COLL0);
    add("rd_r0",         0, 0,  1, 0,  0, 0, 0,     0, 0, 0,     V5555, VDEAD);
    add("wr_r1_10",      0, 0,  0, 0,  1, 1, V10,   0, 0, 0,     V5555, VDEAD);
    add("rd_r1_10",      1, 1,  0, 0,  0, 0, 0,     0, 0, 0,     V10,   VDEAD);
    add("hold_wr_r1",    0, 1,  0, 0,  1, 1, V20,   0, 0, 0,     V10,   VDEAD);
    add("hold_2",        0, 1,  0, 0,  0, 0, 0,     0, 0, 0,     V10,   VDEAD);
    add("hold_3",        0, 1,  0, 0,  0, 0, 0,     0, 0, 0,     V10,   VDEAD);
    add("rd_r1_20",      1, 1,  0, 0,  0, 0, 0,     0, 0, 0,     V20,   VDEAD);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      ren0 = vecs[i].ren0; raddr0 = vecs[i].raddr0;
      ren1 = vecs[i].ren1; raddr1 = vecs[i].raddr1;
      wen0 = vecs[i].wen0; waddr0 = vecs[i].waddr0; wdata0 = vecs[i].wdata0;
      wen1 = vecs[i].wen1; waddr1 = vecs[i].waddr1; wdata1 = vecs[i].wdata1;
      @(posedge clk);
      #1;
      check({vecs[i].name, "_rdata0"}, rdata0, vecs[i].exp0);
      check({vecs[i].name, "_rdata1"}, rdata1, vecs[i].exp1);
    end

    // Reset between edges clears outputs immediately.
    @(negedge clk);
    idle();
    #1 rst = 1'b1;
    #1;
    check("midreset_rdata0", rdata0, 64'h0);
    check("midreset_rdata1", rdata1, 64'h0);

    // Write and read during reset are ignored.
    wen0 = 1; waddr0 = 5'd2; wdata0 = 64'hFFFF_FFFF_FFFF_FFFF;
    ren0 = 1; raddr0 = 5'd2; ren1 = 1; raddr1 = 5'd2;
    @(posedge clk);
    #1;
    check("inreset_rdata0", rdata0, 64'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Every register reads back zero after reset.
    for (int a = 0; a < 32; a += 2) begin
      @(negedge clk);
      ren0 = 1; raddr0 = 5'(a);
      ren1 = 1; raddr1 = 5'(a + 1);
      @(posedge clk);
      #1;
      check($sformatf("postreset_r%0d", a), rdata0, 64'h0);
      check($sformatf("postreset_r%0d", a + 1), rdata1, 64'h0);
    end

    // First edge after reset operates normally.
    @(negedge clk);
    idle();
    wen1 = 1; waddr1 = 5'd9; wdata1 = V3333;
    @(posedge clk);
    @(negedge clk);
    idle();
    ren0 = 1; raddr0 = 5'd9;
    @(posedge clk);
    #1;
    check("postreset_wr_r9", rdata0, V3333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
